// File: rtl/program_loader_if.sv
// Byte-link and instruction-memory write port bundle for the program loader.
// No storage of its own; purely wiring between host link, loader and memory.
// master = loader side (consumes bytes, drives memory); slave = environment side.
interface program_loader_if #(
   parameter int ADDR_W = 4,
   parameter int INST_W = 13
) ();
   logic [7:0]        data_in;
   logic              data_valid;
   logic              data_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [INST_W-1:0] mem_data;

   modport master (
      input  data_in,
      input  data_valid,
      output data_ready,
      output mem_we,
      output mem_addr,
      output mem_data
   );

   modport slave (
      output data_in,
      output data_valid,
      input  data_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_data
   );
endinterface

// File: rtl/program_loader.sv
// Loads a HDR/word-pairs/CHK byte stream into instruction memory, holding the CPU until done.
// Latency: one memory write the cycle after each LO byte is accepted; DONE/ERR one cycle after CHK/fault.
// Backpressure: data_ready is high only in HDR, HI, LO and CHK; a byte moves on valid && ready.
module program_loader #(
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16,
   parameter int INST_W = 13
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   program_loader_if.master lnk,
   output logic             cpu_hold_o,
   output logic             done_o,
   output logic             err_o
);
   // Bits of the instruction carried by the HI byte, and width of the word counter.
   localparam int         HI_W  = INST_W - 8;
   localparam int         CNT_W = ADDR_W + 1;
   localparam logic [7:0] MAX_N = 8'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_HI,
      S_LO,
      S_WRITE,
      S_CHK,
      S_DONE,
      S_ERR
   } state_t;

   state_t             state_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [CNT_W-1:0]   n_q;
   logic [HI_W-1:0]    hi_q;
   logic [7:0]         chk_q;
   logic               we_q;
   logic [ADDR_W-1:0]  mem_addr_q;
   logic [INST_W-1:0]  mem_data_q;
   logic               hold_q;
   logic               done_q;
   logic               err_q;

   logic               rdy;
   logic               accept;
   logic               hdr_ok;
   logic               hi_ok;
   logic               last_word;

   // Ready is a pure decode of the states that consume a byte.
   always_comb begin
      rdy = 1'b0;
      case (state_q)
         S_HDR, S_HI, S_LO, S_CHK: rdy = 1'b1;
         default:                  rdy = 1'b0;
      endcase
   end

   assign accept    = lnk.data_valid && rdy;
   // Word count must be 1..DEPTH; anything above DEPTH also covers nonzero [7:5].
   assign hdr_ok    = (lnk.data_in != 8'd0) && (lnk.data_in <= MAX_N);
   assign hi_ok     = (lnk.data_in[7:HI_W] == '0);
   assign last_word = ({1'b0, addr_q} == (n_q - CNT_W'(1)));

   assign lnk.data_ready = rdy;
   // A START landing on the WRITE cycle must suppress that write immediately.
   assign lnk.mem_we     = we_q && !start_i;
   assign lnk.mem_addr   = mem_addr_q;
   assign lnk.mem_data   = mem_data_q;
   assign cpu_hold_o     = hold_q;
   assign done_o         = done_q;
   assign err_o          = err_q;

   // Load sequencer: state, counters, running checksum and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         n_q        <= '0;
         hi_q       <= '0;
         chk_q      <= '0;
         we_q       <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         hold_q     <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else if (start_i) begin
         // Restart from any state; a byte offered this cycle is dropped.
         state_q <= S_HDR;
         addr_q  <= '0;
         chk_q   <= '0;
         we_q    <= 1'b0;
         hold_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         we_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               state_q <= S_IDLE;
            end
            S_HDR: begin
               if (accept) begin
                  if (!hdr_ok) begin
                     state_q <= S_ERR;
                     err_q   <= 1'b1;
                  end else begin
                     n_q     <= lnk.data_in[CNT_W-1:0];
                     addr_q  <= '0;
                     chk_q   <= lnk.data_in;
                     state_q <= S_HI;
                  end
               end
            end
            S_HI: begin
               if (accept) begin
                  if (!hi_ok) begin
                     state_q <= S_ERR;
                     err_q   <= 1'b1;
                  end else begin
                     hi_q    <= lnk.data_in[HI_W-1:0];
                     chk_q   <= chk_q ^ lnk.data_in;
                     state_q <= S_LO;
                  end
               end
            end
            S_LO: begin
               if (accept) begin
                  mem_data_q <= {hi_q, lnk.data_in};
                  mem_addr_q <= addr_q;
                  chk_q      <= chk_q ^ lnk.data_in;
                  we_q       <= 1'b1;
                  state_q    <= S_WRITE;
               end
            end
            S_WRITE: begin
               // Address stops at N-1, so it can never wrap past DEPTH.
               if (last_word) begin
                  state_q <= S_CHK;
               end else begin
                  addr_q  <= addr_q + ADDR_W'(1);
                  state_q <= S_HI;
               end
            end
            S_CHK: begin
               if (accept) begin
                  if (lnk.data_in == chk_q) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     hold_q  <= 1'b0;
                  end else begin
                     state_q <= S_ERR;
                     err_q   <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_DONE;
            end
            S_ERR: begin
               state_q <= S_ERR;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus randomized streams.
// Inputs change 1 time unit after the rising edge; write monitor samples on the falling edge.
// Expected writes and outcome come from a stream-level model, not from the RTL structure.
module tb_program_loader;
   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic cpu_hold;
   logic done;
   logic err;

   always #5 clk = ~clk;

   program_loader_if #(.ADDR_W(4), .INST_W(13)) bus ();

   program_loader #(.ADDR_W(4), .DEPTH(16), .INST_W(13)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .lnk        (bus.master),
      .cpu_hold_o (cpu_hold),
      .done_o     (done),
      .err_o      (err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   int cap_addr[$];
   int cap_data[$];
   int exp_addr[$];
   int exp_data[$];
   int exp_done;

   // Record every memory write seen.
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         cap_addr.push_back(int'(bus.mem_addr));
         cap_data.push_back(int'(bus.mem_data));
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Stream-level reference: what writes happen and whether the load ends good.
   task automatic model(input bq_t s);
      int n;
      logic [7:0] x;
      exp_addr.delete();
      exp_data.delete();
      exp_done = 0;
      n = int'(s[0]);
      if (n < 1 || n > 16) return;
      x = s[0];
      for (int i = 0; i < n; i++) begin
         if (int'(s[1 + 2*i]) > 31) return;
         exp_addr.push_back(i);
         exp_data.push_back(int'(s[1 + 2*i]) * 256 + int'(s[2 + 2*i]));
         x = x ^ s[1 + 2*i] ^ s[2 + 2*i];
      end
      if (s[1 + 2*n] == x) exp_done = 1;
   endtask

   function automatic bq_t build(input int words[$]);
      bq_t s;
      logic [7:0] x;
      s.push_back(8'(words.size()));
      foreach (words[i]) begin
         s.push_back(8'(words[i] >> 8));
         s.push_back(8'(words[i]));
      end
      x = 8'h00;
      foreach (s[i]) x = x ^ s[i];
      s.push_back(x);
      return s;
   endfunction

   // Called at posedge+1; leaves at posedge+1.
   task automatic pulse_start(input logic junk_vld);
      start          = 1'b1;
      bus.data_valid = junk_vld;
      bus.data_in    = 8'hFF;
      @(posedge clk); #1;
      start          = 1'b0;
      bus.data_valid = 1'b0;
      cap_addr.delete();
      cap_data.delete();
   endtask

   // Offer each byte until accepted; stop early once the load has concluded.
   task automatic send(input bq_t s, input int gap_pct);
      foreach (s[i]) begin
         bit acc;
         int budget;
         acc    = 1'b0;
         budget = 0;
         while (!acc) begin
            if (done === 1'b1 || err === 1'b1) begin
               bus.data_valid = 1'b0;
               return;
            end
            if ($urandom_range(0, 99) < gap_pct) begin
               bus.data_valid = 1'b0;
            end else begin
               bus.data_valid = 1'b1;
               bus.data_in    = s[i];
            end
            acc = bus.data_valid && (bus.data_ready === 1'b1);
            @(posedge clk); #1;
            budget++;
            if (budget > 60) begin
               n_checks++;
               n_fail++;
               $error("FAIL send_timeout byte=%0d observed=stalled expected=accepted", i);
               bus.data_valid = 1'b0;
               return;
            end
         end
      end
      bus.data_valid = 1'b0;
   endtask

   task automatic compare_load(input string tag);
      check({tag, "_nwrites"}, cap_addr.size(), exp_addr.size());
      for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
         check({tag, "_addr"}, cap_addr[i], exp_addr[i]);
         check({tag, "_data"}, cap_data[i], exp_data[i]);
      end
      check({tag, "_done"}, done, exp_done == 1);
      check({tag, "_err"}, err, exp_done == 0);
      check({tag, "_hold"}, cpu_hold, exp_done == 0);
      check({tag, "_rdy"}, bus.data_ready, 1'b0);
   endtask

   task automatic run_load(input string tag, input bq_t s, input int gap_pct, input logic junk);
      pulse_start(junk);
      model(s);
      send(s, gap_pct);
      repeat (3) begin
         @(posedge clk); #1;
      end
      compare_load(tag);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_rdy"}, bus.data_ready, 1'b0);
      check({tag, "_we"}, bus.mem_we, 1'b0);
      check({tag, "_addr"}, bus.mem_addr, 0);
      check({tag, "_data"}, bus.mem_data, 0);
      check({tag, "_hold"}, cpu_hold, 1'b1);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_err"}, err, 1'b0);
   endtask

   initial begin
      bq_t s;
      bq_t part;
      int  w[$];
      int  n;

      rst            = 1'b1;
      start          = 1'b0;
      bus.data_valid = 1'b0;
      bus.data_in    = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Single word 0x0A5C; write appears the cycle after LO is accepted.
      pulse_start(1'b0);
      s = '{8'h01, 8'h0A, 8'h5C};
      send(s, 0);
      check("t1_we_latency", bus.mem_we, 1'b1);
      check("t1_addr", bus.mem_addr, 0);
      check("t1_data", bus.mem_data, 13'h0A5C);
      check("t1_rdy_in_write", bus.data_ready, 1'b0);
      s = '{8'h57};
      send(s, 0);
      @(posedge clk); #1;
      check("t1_done", done, 1'b1);
      check("t1_hold", cpu_hold, 1'b0);
      check("t1_nwrites", cap_addr.size(), 1);

      // Full depth, words 0..15, with a junk byte offered alongside a second START.
      w.delete();
      for (int i = 0; i < 16; i++) w.push_back(i);
      pulse_start(1'b0);
      run_load("t2_full", build(w), 0, 1'b1);

      // Bad headers.
      run_load("t3_hdr00", '{8'h00, 8'h00, 8'h01, 8'h01}, 0, 1'b0);
      run_load("t3_hdr11", '{8'h11, 8'h00, 8'h01, 8'h10}, 0, 1'b0);

      // Bad HI byte, then bad checksum after one good word.
      run_load("t4_hi20", '{8'h01, 8'h20, 8'h00, 8'h21}, 0, 1'b0);
      s = '{8'h01, 8'h1F, 8'hA5, 8'h00};
      run_load("t4_badchk", s, 0, 1'b0);

      // Abort a 4-word load on its second write, then load one word.
      pulse_start(1'b0);
      part = '{8'h04, 8'h01, 8'h11, 8'h02, 8'h22};
      send(part, 0);
      check("t5_we_before_cancel", bus.mem_we, 1'b1);
      start = 1'b1;
      #1;
      check("t5_we_cancelled", bus.mem_we, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      check("t5_partial_writes", cap_addr.size(), 1);
      check("t5_restart_done", done, 1'b0);
      w.delete();
      w.push_back(13'h1ABC);
      run_load("t5_reload", build(w), 0, 1'b0);

      // Randomized streams with gaps and occasional corruption.
      for (int it = 0; it < 10; it++) begin
         int mode;
         w.delete();
         n = $urandom_range(1, 16);
         for (int i = 0; i < n; i++) w.push_back($urandom_range(0, 8191));
         s = build(w);
         mode = $urandom_range(0, 3);
         if (mode == 0) s[s.size() - 1] = s[s.size() - 1] ^ 8'h01;
         if (mode == 1) s[1 + 2 * $urandom_range(0, n - 1)] = 8'(8'h20 | $urandom_range(0, 255));
         run_load("t6_rand", s, 30, 1'b0);
      end

      // Reset in the middle of a load, together with START.
      w.delete();
      for (int i = 0; i < 8; i++) w.push_back($urandom_range(0, 8191));
      s = build(w);
      part.delete();
      for (int i = 0; i < 7; i++) part.push_back(s[i]);
      pulse_start(1'b0);
      send(part, 20);
      check("t6_midload_hold", cpu_hold, 1'b1);
      rst   = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_reset("t6_rst");
      rst = 1'b0;
      @(posedge clk); #1;
      check("t6_idle_rdy", bus.data_ready, 1'b0);
      run_load("t6_after_rst", s, 20, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
